// File: rtl/cfg_reg_pkg.sv
// Shared constants for the system configuration register file: address map
// of the exported registers and the bit layout of the UART configuration byte.
package cfg_reg_pkg;

  // Exported register addresses (ALU operands, UART config, clock divider)
  localparam int ADDR_ALU_OP_A  = 0;
  localparam int ADDR_ALU_OP_B  = 1;
  localparam int ADDR_UART_CFG  = 2;
  localparam int ADDR_DIV_RATIO = 3;

  // UART_CFG field offsets
  localparam int UART_PAR_EN       = 0;
  localparam int UART_PAR_TYPE     = 1;
  localparam int UART_PRESCALE_LSB = 2;
  localparam int UART_PRESCALE_MSB = 7;
  localparam int UART_CFG_W        = UART_PRESCALE_MSB + 1;

  // Builds the UART_CFG reset byte from its three field values.
  // Only the low bits of each argument are meaningful.
  function automatic logic [UART_CFG_W-1:0] uart_cfg_reset(input int prescale,
                                                           input int par_type,
                                                           input int par_en);
    logic [UART_CFG_W-1:0] v;
    logic [31:0]           p;
    logic [31:0]           t;
    logic [31:0]           e;
    p = prescale;
    t = par_type;
    e = par_en;
    v = '0;
    v[UART_PAR_EN]                             = e[0];
    v[UART_PAR_TYPE]                           = t[0];
    v[UART_PRESCALE_MSB:UART_PRESCALE_LSB]     = p[5:0];
    return v;
  endfunction

endpackage

// File: rtl/cfg_reg_file_if.sv
// Controller-side bus of the configuration register file plus the flat
// export bus that feeds the ALU, UART and clock divider.
interface cfg_reg_file_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 4,
  parameter int NUM_EXPORT = 4
);

  logic [WIDTH-1:0]            WrData;
  logic [ADDR_W-1:0]           Address;
  logic                        WrEn;
  logic                        RdEn;
  logic                        Lock;
  logic [WIDTH-1:0]            RdData;
  logic                        RdData_Valid;
  logic                        Err;
  logic                        Cfg_Update;
  logic [NUM_EXPORT*WIDTH-1:0] REG_Export;

  // System controller side
  modport master (
    output WrData, Address, WrEn, RdEn, Lock,
    input  RdData, RdData_Valid, Err, Cfg_Update, REG_Export
  );

  // Register file side
  modport slave (
    input  WrData, Address, WrEn, RdEn, Lock,
    output RdData, RdData_Valid, Err, Cfg_Update, REG_Export
  );

endinterface

// File: rtl/cfg_reg_access_chk.sv
// Combinational access qualification: decides whether the current request is
// a legal read, a legal write, or must be rejected with an error strobe.
module cfg_reg_access_chk
  import cfg_reg_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_EXPORT = 4
) (
  input  logic [ADDR_W-1:0] Address,
  input  logic              WrEn,
  input  logic              RdEn,
  input  logic              Lock,
  input  logic [DEPTH-1:0]  RO_MASK,
  output logic              rd_ok,
  output logic              wr_ok,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_exported;
  logic             w_ro;
  logic             w_locked;
  logic             w_rd_only;
  logic             w_wr_only;

  assign w_in_range = (32'(Address) < 32'(DEPTH));
  assign w_exported = (32'(Address) < 32'(NUM_EXPORT));
  assign w_idx      = IDX_W'(Address);

  // Out-of-range addresses never consult the mask; they are rejected anyway
  assign w_ro       = w_in_range & RO_MASK[w_idx];
  assign w_locked   = Lock & w_exported;

  // A simultaneous read and write is a collision, neither side is serviced
  assign w_rd_only  = RdEn & ~WrEn;
  assign w_wr_only  = WrEn & ~RdEn;

  assign rd_ok = w_rd_only & w_in_range;
  assign wr_ok = w_wr_only & w_in_range & ~w_ro & ~w_locked;
  assign err   = (RdEn & WrEn)
               | (w_rd_only & ~w_in_range)
               | (w_wr_only & ~wr_ok);

endmodule

// File: rtl/cfg_reg_file.sv
// Parametrised system configuration register file. Holds DEPTH registers,
// exports the lowest NUM_EXPORT continuously, and flags rejected accesses
// and value changes of exported registers with one-cycle strobes.
module cfg_reg_file
  import cfg_reg_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               DEPTH         = 16,
  parameter int               ADDR_W        = 4,
  parameter int               NUM_EXPORT    = 4,
  parameter logic [DEPTH-1:0] RO_MASK       = '0,
  parameter int               PARITY_ENABLE = 0,
  parameter int               PARITY_TYPE   = 0,
  parameter int               PRESCALE      = 8,
  parameter int               DIV_RATIO     = 8
) (
  input  logic           CLK,
  input  logic           RST,
  cfg_reg_file_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WIDTH-1:0] L_UART_RST =
    WIDTH'(uart_cfg_reset(PRESCALE, PARITY_TYPE, PARITY_ENABLE));
  localparam logic [WIDTH-1:0] L_DIV_RST  = WIDTH'(DIV_RATIO);

  logic [WIDTH-1:0]            r_mem [DEPTH];
  logic [WIDTH-1:0]            r_rd_data;
  logic                        r_rd_valid;
  logic                        r_err;
  logic                        r_cfg_update;

  logic                        w_rd_ok;
  logic                        w_wr_ok;
  logic                        w_err;
  logic                        w_rd_only;
  logic                        w_exported;
  logic                        w_changed;
  logic [IDX_W-1:0]            w_idx;
  logic [NUM_EXPORT*WIDTH-1:0] w_export;

  cfg_reg_access_chk #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .NUM_EXPORT (NUM_EXPORT)
  ) u_access_chk (
    .Address (bus.Address),
    .WrEn    (bus.WrEn),
    .RdEn    (bus.RdEn),
    .Lock    (bus.Lock),
    .RO_MASK (RO_MASK),
    .rd_ok   (w_rd_ok),
    .wr_ok   (w_wr_ok),
    .err     (w_err)
  );

  assign w_idx      = IDX_W'(bus.Address);
  assign w_rd_only  = bus.RdEn & ~bus.WrEn;
  assign w_exported = (32'(bus.Address) < 32'(NUM_EXPORT));
  assign w_changed  = (r_mem[w_idx] != bus.WrData);

  // Storage, read data and strobes; strobes default low so each pulse is one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_mem[ADDR_UART_CFG]  <= L_UART_RST;
      r_mem[ADDR_DIV_RATIO] <= L_DIV_RST;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_cfg_update <= 1'b0;
    end else begin
      r_rd_valid   <= 1'b0;
      r_cfg_update <= 1'b0;
      r_err        <= w_err;
      // Out-of-range reads still complete, returning zero alongside Err
      if (w_rd_only) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_rd_ok ? r_mem[w_idx] : '0;
      end
      if (w_wr_ok) begin
        r_mem[w_idx] <= bus.WrData;
        r_cfg_update <= w_exported & w_changed;
      end
    end
  end

  // Flatten the exported registers onto the export bus
  always_comb begin
    w_export = '0;
    for (int i = 0; i < NUM_EXPORT; i++) begin
      w_export[i*WIDTH +: WIDTH] = r_mem[i];
    end
  end

  assign bus.RdData       = r_rd_data;
  assign bus.RdData_Valid = r_rd_valid;
  assign bus.Err          = r_err;
  assign bus.Cfg_Update   = r_cfg_update;
  assign bus.REG_Export   = w_export;

endmodule
